// File: rtl/md_pkg.sv
// md_pkg: shared op codes, FSM states and default latencies for the multiply/divide sequencer
package md_pkg;
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;
  typedef enum logic {ST_IDLE, ST_RUN} md_state_e;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
endpackage

// File: rtl/md_alu.sv
// md_alu: combinational multiply/divide result (hi/lo) for one md request
// Ports: i_op (md op), i_a/i_b (operands), i_cur_hi/i_cur_lo (current HI/LO),
//        o_res_hi/o_res_lo (result; current HI/LO for divide by zero and non-arith ops)
module md_alu
  import md_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_cur_hi,
  input  logic [31:0] i_cur_lo,
  output logic [31:0] o_res_hi,
  output logic [31:0] o_res_lo
);
  logic        w_sgn, w_na, w_nb, w_dz, w_mul, w_dv;
  logic [31:0] w_ma, w_mb, w_div, w_q, w_r, w_qs, w_rs;
  logic [63:0] w_prod_u, w_prod;
  // signed ops run on magnitudes; result signs are restored afterwards
  assign w_sgn    = (i_op == MD_MULT) || (i_op == MD_DIV);
  assign w_na     = w_sgn & i_a[31];
  assign w_nb     = w_sgn & i_b[31];
  assign w_ma     = w_na ? -i_a : i_a;
  assign w_mb     = w_nb ? -i_b : i_b;
  assign w_prod_u = {32'd0, w_ma} * {32'd0, w_mb};
  assign w_prod   = (w_na ^ w_nb) ? -w_prod_u : w_prod_u;
  assign w_dz     = (i_b == 32'd0);
  assign w_div    = w_dz ? 32'd1 : w_mb;
  assign w_q      = w_ma / w_div;
  assign w_r      = w_ma % w_div;
  // quotient truncates toward zero, remainder follows the dividend sign
  assign w_qs     = (w_na ^ w_nb) ? -w_q : w_q;
  assign w_rs     = w_na ? -w_r : w_r;
  assign w_mul    = (i_op == MD_MULT) || (i_op == MD_MULTU);
  assign w_dv     = ((i_op == MD_DIV) || (i_op == MD_DIVU)) && !w_dz;
  assign o_res_hi = w_mul ? w_prod[63:32] : w_dv ? w_rs : i_cur_hi;
  assign o_res_lo = w_mul ? w_prod[31:0]  : w_dv ? w_qs : i_cur_lo;
endmodule

// File: rtl/md_sched.sv
// md_sched: multi-cycle multiply/divide sequencer owning HI/LO and the D-stage md stall
// Ports: i_clk, i_reset (sync, active-low), i_start/i_op/i_a/i_b (E-stage request),
//        i_cancel (flush), i_d_is_md (D-stage md-class), o_busy, o_stall_md, o_hi, o_lo
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cancel,
  input  logic        i_d_is_md,
  output logic        o_busy,
  output logic        o_stall_md,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);
  md_state_e   r_state;
  logic [15:0] r_cnt;
  logic [31:0] r_pend_hi, r_pend_lo, r_hi, r_lo;
  logic [31:0] w_res_hi, w_res_lo;
  logic        w_arith;
  assign w_arith = (i_op <= MD_DIVU);
  md_alu u_alu (
    .i_op     (i_op),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_cur_hi (r_hi),
    .i_cur_lo (r_lo),
    .o_res_hi (w_res_hi),
    .o_res_lo (w_res_lo)
  );
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else if (r_state == ST_RUN) begin
      if (i_cancel) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt - 16'd1;
        if (r_cnt == 16'd1) begin
          r_hi    <= r_pend_hi;
          r_lo    <= r_pend_lo;
          r_state <= ST_IDLE;
        end
      end
    end else if (i_start && !i_cancel) begin
      if (w_arith) begin
        r_pend_hi <= w_res_hi;
        r_pend_lo <= w_res_lo;
        r_cnt     <= i_op[1] ? 16'(DIV_CYCLES) : 16'(MULT_CYCLES);
        r_state   <= ST_RUN;
      end
      if (i_op == MD_MTHI) r_hi <= i_a;
      if (i_op == MD_MTLO) r_lo <= i_a;
    end
  end
  assign o_busy     = (r_state == ST_RUN);
  assign o_stall_md = i_d_is_md & (o_busy | (i_start & w_arith));
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;
endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Sequencer for the multiply/divide resource used by the E stage.
- Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO request at a time and models multi-cycle latency with a countdown.
- Owns the architectural HI/LO registers.
- Generates the stall request that freezes the D pipeline register while a later md-class instruction would otherwise proceed.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >=1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >=1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  E stage issues md request this cycle
- op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, others no-op
- a  in  32  forwarded rs value (E stage)
- b  in  32  forwarded rt value (E stage)
- cancel  in  1  exception/flush; aborts in-flight operation
- d_is_md  in  1  D-stage instruction is md-class (mult/div/mthi/mtlo/mfhi/mflo)
- busy  out  1  operation in flight
- stall_md  out  1  stall D stage
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (reset==0 at a rising edge): state IDLE, counter 0, hi=0, lo=0, pending regs 0, busy=0. This takes priority over all other inputs, including mid-operation (the in-flight result is discarded).
- States: IDLE, RUN.
- IDLE:
  - start with op 0..3 → latch the computed result into pend_hi/pend_lo, load counter with MULT_CYCLES or DIV_CYCLES, go to RUN.
  - start with op 4 → hi<=a at this edge; stay IDLE.
  - start with op 5 → lo<=a at this edge; stay IDLE.
  - op 6/7 → ignored.
- RUN:
  - Counter decrements every edge.
  - At the edge where counter==1: hi<=pend_hi, lo<=pend_lo, go to IDLE.
  - busy==1 for exactly N cycles after the start edge. The new hi/lo are visible the cycle busy falls.
- start while in RUN: ignored. The D-stage stall prevents this legally; no state change.
- cancel:
  - In RUN: go to IDLE, hi/lo unchanged.
  - In IDLE with start in the same cycle: cancel wins, request dropped (including MTHI/MTLO).
- busy = (state==RUN).
- stall_md = d_is_md & (busy | (start & op<=3)). This is combinational and does not depend on cancel.
- Arithmetic:
  - MULT: signed 32x32→64; hi=[63:32], lo=[31:0].
  - MULTU: unsigned.
  - DIV: signed, quotient truncated toward zero → lo; remainder → hi, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU: unsigned.
- Divide by zero (b==0, op 2/3): the full DIV_CYCLES busy period still runs, then hi/lo stay unchanged (pend_hi/pend_lo loaded with the current hi/lo).
- Back-to-back: a start arriving the cycle busy falls is accepted normally.

Decomposition:
- Shared package md_pkg holds:
  - op encodings (MD_MULT..MD_MTLO)
  - state encoding (ST_IDLE, ST_RUN)
  - default cycle counts
- One sub-module, md_alu: purely combinational (op, a, b, cur_hi, cur_lo) → (res_hi, res_lo). It includes the signed/unsigned and divide-by-zero rules.
- md_sched holds the FSM, counter, pending registers and HI/LO.

Test Plan:
1. Reset low 2 cycles mid-DIV (cycle 3 of 10) → busy=0, hi=lo=0 next cycle; no later commit.
2. MULT a=0xFFFFFFFF b=2 → busy high 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE. Repeated as MULTU → hi=0x00000001 lo=0xFFFFFFFE.
3. DIV a=0xFFFFFFF9 (−7) b=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2.
4. DIVU b=0 with hi=0x11, lo=0x22 preset via MTHI/MTLO → busy 10 cycles, hi=0x11 lo=0x22 after.
5. start MULT with d_is_md=1 held → stall_md=1 on the start cycle and all 5 busy cycles, 0 the cycle after. With d_is_md=0 → stall_md=0 throughout.
6. cancel at busy cycle 2 of MULT → busy drops next cycle, hi/lo unchanged. cancel together with start MTHI a=5 → hi unchanged.
